// File: rtl/instr_fetch.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// tracking with redirect squashing, and a small instruction queue toward decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [29:0]   pc_reg;
    logic [CW-1:0] outstanding_reg;
    logic [CW-1:0] discard_reg;
    logic [CW-1:0] occ_reg;
    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [PW-1:0] fl_rd_reg;
    logic [PW-1:0] fl_wr_reg;

    logic [31:0] q_instr [DEPTH];
    logic [31:0] q_pc    [DEPTH];
    logic [31:0] fl_pc   [DEPTH];

    logic [SW-1:0] in_use;
    logic          accept;
    logic          rsp_take;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic [31:0]   fl_head;
    logic          unused_bits;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Squashed requests still hold a credit until their response comes back.
    assign in_use = SW'(outstanding_reg) + SW'(discard_reg) + SW'(occ_reg);

    assign imem_req_valid = rst_n & ~redirect_valid & (in_use < SW'(DEPTH));
    assign imem_req_addr  = {pc_reg, 2'b00};
    assign accept         = imem_req_valid & imem_req_ready;

    // Responses with nothing in flight are ignored without touching the PC FIFO.
    assign rsp_take = imem_rsp_valid & ((outstanding_reg != '0) | (discard_reg != '0));
    assign rsp_drop = rsp_take & (discard_reg != '0);
    assign push     = rsp_take & (discard_reg == '0) & ~redirect_valid;
    assign pop      = out_valid & out_ready;
    assign fl_head  = fl_pc[fl_rd_reg];

    assign out_valid = (occ_reg != '0);
    assign out_instr = q_instr[head_reg];
    assign out_pc    = q_pc[head_reg];

    assign unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC[31:2];
            outstanding_reg <= '0;
            discard_reg     <= '0;
            occ_reg         <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            fl_rd_reg       <= '0;
            fl_wr_reg       <= '0;
        end else begin
            if (redirect_valid)
                pc_reg <= redirect_pc[31:2];
            else if (accept)
                pc_reg <= pc_reg + 30'd1;

            if (accept)
                fl_wr_reg <= next_ptr(fl_wr_reg);
            if (rsp_take)
                fl_rd_reg <= next_ptr(fl_rd_reg);

            if (redirect_valid) begin
                // Everything still in flight becomes a response to discard.
                outstanding_reg <= '0;
                discard_reg     <= discard_reg + outstanding_reg - CW'(rsp_take);
                occ_reg         <= '0;
                head_reg        <= '0;
                tail_reg        <= '0;
            end else begin
                outstanding_reg <= outstanding_reg + CW'(accept) - CW'(rsp_take & ~rsp_drop);
                discard_reg     <= discard_reg - CW'(rsp_drop);
                occ_reg         <= occ_reg + CW'(push) - CW'(pop);
                if (push)
                    tail_reg <= next_ptr(tail_reg);
                if (pop)
                    head_reg <= next_ptr(head_reg);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [31:0] instr_reg;
            logic [31:0] pc_slot_reg;
            logic [31:0] fl_slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    instr_reg   <= '0;
                    pc_slot_reg <= '0;
                    fl_slot_reg <= '0;
                end else begin
                    if (push && tail_reg == PW'(gi)) begin
                        instr_reg   <= imem_rsp_data;
                        pc_slot_reg <= fl_head;
                    end
                    if (accept && fl_wr_reg == PW'(gi))
                        fl_slot_reg <= imem_req_addr;
                end
            end

            assign q_instr[gi] = instr_reg;
            assign q_pc[gi]    = pc_slot_reg;
            assign fl_pc[gi]   = fl_slot_reg;
        end
    endgenerate

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, randomized traffic against an
// epoch-tagged transaction model, and a mid-burst reset sequence.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    typedef struct { logic [31:0] addr; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct {
        logic rv; logic [31:0] rpc; logic rdy; logic rsp; logic ordy;
        logic e_rv; logic [31:0] e_addr; logic e_ov; logic [31:0] e_pc;
    } vec_t;

    req_t memq[$];      // requests accepted by memory, awaiting response
    ent_t expq[$];      // instructions the DUT queue should be holding
    vec_t vecs[$];
    int   epoch = 0;
    int   abandoned = 0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] m_pc = RESET_PC;

    logic        s_req_valid, s_out_valid;
    logic [31:0] s_req_addr, s_out_pc, s_out_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample, compare with model, advance model.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy,
                        input logic rsp, input logic ordy);
        logic deliver;
        bit   exp_req;
        req_t r;
        ent_t e;
        @(negedge clk);
        deliver        = rsp && (memq.size() != 0);
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        out_ready      = ordy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = deliver ? mem_word(memq[0].addr) : 32'hDEAD_BEEF;
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instr;

        check("out_valid", 32'(s_out_valid), 32'(expq.size() != 0));
        if (expq.size() != 0) begin
            check("out_pc", s_out_pc, expq[0].pc);
            check("out_instr", s_out_instr, expq[0].instr);
        end
        exp_req = !rv && ((memq.size() - abandoned + expq.size()) < DEPTH);
        check("req_valid", 32'(s_req_valid), 32'(exp_req));
        if (exp_req)
            check("req_addr", s_req_addr, m_pc);

        if (ordy && expq.size() != 0)
            void'(expq.pop_front());
        if (deliver) begin
            r = memq.pop_front();
            if (abandoned > 0)
                abandoned--;
            else if (r.epoch == epoch && !rv) begin
                e.pc = r.addr;
                e.instr = mem_word(r.addr);
                expq.push_back(e);
            end
        end
        if (rv) begin
            expq.delete();
            epoch++;
            m_pc = {rpc[31:2], 2'b00};
        end
        if (exp_req && rdy) begin
            r.addr = m_pc;
            r.epoch = epoch;
            memq.push_back(r);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy, input logic rsp,
                       input logic ordy, input logic e_rv, input logic [31:0] e_addr,
                       input logic e_ov, input logic [31:0] e_pc);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rsp = rsp; v.ordy = ordy;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rpc;
        logic        rsp;
        int          n;

        rst_n = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        #12;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        @(negedge clk); #2; rst_n = 1'b1;

        // rv rpc rdy rsp ordy | req_valid req_addr out_valid out_pc
        add(0, 0,            1, 1, 1,  1, 32'h0,        0, 0);
        add(0, 0,            1, 1, 1,  1, 32'h4,        0, 0);
        add(0, 0,            1, 1, 1,  0, 0,            1, 32'h0);
        add(0, 0,            1, 1, 1,  1, 32'h8,        1, 32'h4);
        add(0, 0,            1, 1, 1,  1, 32'hC,        0, 0);
        add(0, 0,            1, 1, 1,  0, 0,            1, 32'h8);
        add(0, 0,            1, 1, 1,  1, 32'h10,       1, 32'hC);
        add(0, 0,            1, 1, 0,  1, 32'h14,       0, 0);
        add(0, 0,            1, 1, 0,  0, 0,            1, 32'h10);
        add(0, 0,            1, 1, 0,  0, 0,            1, 32'h10);
        add(0, 0,            1, 1, 0,  0, 0,            1, 32'h10);
        add(0, 0,            1, 1, 1,  0, 0,            1, 32'h10);
        add(0, 0,            1, 1, 1,  1, 32'h18,       1, 32'h14);
        add(0, 0,            1, 0, 1,  1, 32'h1C,       0, 0);
        add(1, 32'h102,      1, 0, 1,  0, 0,            0, 0);
        add(0, 0,            1, 1, 1,  0, 0,            0, 0);
        add(0, 0,            1, 1, 1,  1, 32'h100,      0, 0);
        add(0, 0,            1, 1, 1,  1, 32'h104,      0, 0);
        add(0, 0,            1, 1, 1,  0, 0,            1, 32'h100);
        add(1, 32'hFFFF_FFFC,1, 1, 1,  0, 0,            1, 32'h104);
        add(0, 0,            1, 1, 1,  1, 32'hFFFF_FFFC,0, 0);
        add(0, 0,            1, 1, 1,  1, 32'h0,        0, 0);
        add(0, 0,            1, 1, 1,  0, 0,            1, 32'hFFFF_FFFC);
        add(0, 0,            1, 1, 1,  1, 32'h4,        1, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rsp, vecs[i].ordy);
            check($sformatf("tbl%0d_req_valid", i), 32'(s_req_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv)
                check($sformatf("tbl%0d_req_addr", i), s_req_addr, vecs[i].e_addr);
            check($sformatf("tbl%0d_out_valid", i), 32'(s_out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                check($sformatf("tbl%0d_out_pc", i), s_out_pc, vecs[i].e_pc);
        end

        for (int c = 0; c < 800; c++) begin
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0)
                rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            rsp = (memq.size() != 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0, rsp,
                 $urandom_range(0, 9) < 7);
        end

        // Drain, then build two outstanding requests before a mid-burst reset.
        n = 0;
        while ((memq.size() != 0 || expq.size() != 0) && n < 20) begin
            step(0, 0, 0, 1, 1);
            n++;
        end
        check("drain_before_reset", 32'(n < 20), 32'd1);
        repeat (3) step(0, 0, 1, 0, 1);

        @(posedge clk); #3;
        rst_n = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; redirect_valid = 0; out_ready = 0;
        #1;
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        check("midrst_req_addr", imem_req_addr, RESET_PC);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_instr", out_instr, 32'd0);
        check("midrst_out_pc", out_pc, 32'd0);
        abandoned = memq.size();
        expq.delete();
        epoch++;
        m_pc = RESET_PC;
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1;

        // Late responses arrive while fetch is held off; they must be ignored.
        while (abandoned > 0)
            step(0, 0, 0, 1, 1);
        repeat (8) step(0, 0, 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
